// File: rtl/freq_meter_pkg.sv
// ============================================================================
// freq_meter_pkg : shared types and limits for the signal frequency meter
// Rev 1.0
// ============================================================================
`default_nettype none

package freq_meter_pkg;

    localparam int COUNT_W = 14;

    localparam logic [COUNT_W-1:0] OVER_LIMIT  = 14'd8000;
    localparam logic [COUNT_W-1:0] UNDER_LIMIT = 14'd100;
    localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } cmp_state_e;

endpackage

`default_nettype wire

// File: rtl/hysteresis_edge_detector.sv
// ============================================================================
// hysteresis_edge_detector : three-state comparator, strobes on LOW->HIGH
// Rev 1.0
// ============================================================================
`default_nettype none

module hysteresis_edge_detector
    import freq_meter_pkg::*;
#(
    parameter logic [7:0] HYST_HIGH = 8'd160,
    parameter logic [7:0] HYST_LOW  = 8'd96
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [7:0] sample_i,
    output logic       rising_crossing_o
);

    cmp_state_e state_q;
    cmp_state_e state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe is combinational so the top can count a crossing in the same
    // cycle that closes a window.
    always_comb begin
        state_d           = state_q;
        rising_crossing_o = 1'b0;
        if (!enable_i) begin
            state_d = INIT;
        end else begin
            case (state_q)
                INIT: begin
                    if (sample_i >= HYST_HIGH) begin
                        state_d = HIGH;
                    end else if (sample_i <= HYST_LOW) begin
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (sample_i >= HYST_HIGH) begin
                        state_d           = HIGH;
                        rising_crossing_o = 1'b1;
                    end
                end
                HIGH: begin
                    if (sample_i <= HYST_LOW) begin
                        state_d = LOW;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/signal_frequency_meter.sv
// ============================================================================
// signal_frequency_meter : counts rising crossings over a fixed gate window
// Rev 1.0
// ============================================================================
`default_nettype none

module signal_frequency_meter
    import freq_meter_pkg::*;
#(
    parameter int         GATE_CYCLES = 32000,
    parameter logic [7:0] HYST_HIGH   = 8'd160,
    parameter logic [7:0] HYST_LOW    = 8'd96
) (
    input  logic               CLK_32KHz,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         inputSample,
    output logic [COUNT_W-1:0] outputFrequency,
    output logic               frequencyValid,
    output logic               overRange,
    output logic               underRange
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic               rising_crossing;
    logic [GATE_W-1:0]  gate_q,  gate_d;
    logic [COUNT_W-1:0] edge_q,  edge_d;
    logic [COUNT_W-1:0] freq_q,  freq_d;
    logic               valid_q, valid_d;
    logic               over_q,  over_d;
    logic               under_q, under_d;
    logic [COUNT_W-1:0] edge_inc;

    hysteresis_edge_detector #(
        .HYST_HIGH (HYST_HIGH),
        .HYST_LOW  (HYST_LOW)
    ) u_detector (
        .clk_i             (CLK_32KHz),
        .rst_i             (reset),
        .enable_i          (enable),
        .sample_i          (inputSample),
        .rising_crossing_o (rising_crossing)
    );

    // Saturating count including this cycle's crossing.
    assign edge_inc = edge_q + COUNT_W'(rising_crossing && (edge_q != COUNT_MAX));

    always_comb begin
        gate_d  = gate_q;
        edge_d  = edge_q;
        freq_d  = freq_q;
        valid_d = 1'b0;
        over_d  = over_q;
        under_d = under_q;
        if (!enable) begin
            gate_d = '0;
            edge_d = '0;
        end else if (gate_q == GATE_LAST) begin
            gate_d  = '0;
            edge_d  = '0;
            freq_d  = edge_inc;
            valid_d = 1'b1;
            over_d  = (edge_inc > OVER_LIMIT);
            under_d = (edge_inc < UNDER_LIMIT);
        end else begin
            gate_d = gate_q + GATE_W'(1);
            edge_d = edge_inc;
        end
    end

    always_ff @(posedge CLK_32KHz) begin
        if (reset) begin
            gate_q  <= '0;
            edge_q  <= '0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            over_q  <= over_d;
            under_q <= under_d;
        end
    end

    assign outputFrequency = freq_q;
    assign frequencyValid  = valid_q;
    assign overRange       = over_q;
    assign underRange      = under_q;

endmodule

`default_nettype wire

// File: tb/tb_signal_frequency_meter.sv
// ============================================================================
// tb_signal_frequency_meter : directed checks on two shortened-gate meters
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_signal_frequency_meter;

    localparam int G  = 3200;   // 32-cycle triangle -> 100 crossings/window
    localparam int G2 = 16002;  // alternating 0/255 -> 8001 crossings/window

    localparam int M_TRI   = 0;
    localparam int M_C200  = 1;
    localparam int M_ALT   = 2;
    localparam int M_BAND  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        en,  en2;
    logic [7:0]  smp, smp2;
    logic [13:0] freq, freq2;
    logic        valid, valid2, over, over2, under, under2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    signal_frequency_meter #(.GATE_CYCLES(G)) u_dut (
        .CLK_32KHz       (clk),
        .reset           (rst),
        .enable          (en),
        .inputSample     (smp),
        .outputFrequency (freq),
        .frequencyValid  (valid),
        .overRange       (over),
        .underRange      (under)
    );

    signal_frequency_meter #(.GATE_CYCLES(G2)) u_dut_long (
        .CLK_32KHz       (clk),
        .reset           (rst),
        .enable          (en2),
        .inputSample     (smp2),
        .outputFrequency (freq2),
        .frequencyValid  (valid2),
        .overRange       (over2),
        .underRange      (under2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int mode, input int k);
        int p;
        p = (4 * k) % 128;
        case (mode)
            M_TRI:   gen = (p < 64) ? 8'(p * 4) : 8'((127 - p) * 4);
            M_C200:  gen = 8'd200;
            M_ALT:   gen = (k % 2 == 1) ? 8'd255 : 8'd0;
            default: gen = (k == 0) ? 8'd0 : ((k % 2 == 1) ? 8'd140 : 8'd120);
        endcase
    endfunction

    // Runs n cycles of a pattern on one meter, recording pulse timing/value.
    task automatic run(input int n, input int mode, input bit use_long,
                       output int pulses, output int first_cyc, output int last_cyc,
                       output logic [13:0] val, output logic ov, output logic un);
        pulses = 0; first_cyc = 0; last_cyc = 0; val = '0; ov = 1'b0; un = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (use_long) smp2 = gen(mode, k);
            else          smp  = gen(mode, k);
            @(posedge clk);
            #1;
            if (use_long ? valid2 : valid) begin
                pulses++;
                if (first_cyc == 0) first_cyc = k + 1;
                last_cyc = k + 1;
                val = use_long ? freq2 : freq;
                ov  = use_long ? over2 : over;
                un  = use_long ? under2 : under;
            end
        end
    endtask

    task automatic idle_cycle();
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid_low", 32'(valid), 32'd0);
        en = 1'b1;
    endtask

    int          p, fc, lc;
    logic [13:0] v;
    logic        o, u;

    initial begin
        rst = 1'b1; en = 1'b0; en2 = 1'b0; smp = 8'd128; smp2 = 8'd128;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_freq",  32'(freq),  32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_over",  32'(over),  32'd0);
        chk("reset_under", 32'(under), 32'd0);
        rst = 1'b0;

        // 1 kHz-equivalent triangle over two windows
        en = 1'b1;
        run(2 * G, M_TRI, 1'b0, p, fc, lc, v, o, u);
        chk("tri_pulses",    32'(p),  32'd2);
        chk("tri_first_at",  32'(fc), 32'(G));
        chk("tri_second_at", 32'(lc), 32'(2 * G));
        chk("tri_value",     32'(v),  32'd100);
        chk("tri_over",      32'(o),  32'd0);
        chk("tri_under",     32'(u),  32'd0);

        // Enable dropped mid-window for 50 cycles
        run(1000, M_TRI, 1'b0, p, fc, lc, v, o, u);
        chk("pre_drop_pulses", 32'(p), 32'd0);
        en = 1'b0;
        run(50, M_TRI, 1'b0, p, fc, lc, v, o, u);
        chk("drop_pulses", 32'(p), 32'd0);
        chk("drop_hold",   32'(freq), 32'd100);
        en = 1'b1;
        run(G, M_TRI, 1'b0, p, fc, lc, v, o, u);
        chk("reen_first_at", 32'(fc), 32'(G));
        chk("reen_value",    32'(v),  32'd100);

        // Reset mid-window
        run(1000, M_TRI, 1'b0, p, fc, lc, v, o, u);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_freq",  32'(freq),  32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        run(G, M_TRI, 1'b0, p, fc, lc, v, o, u);
        chk("postrst_first_at", 32'(fc), 32'(G));
        chk("postrst_value",    32'(v),  32'd100);

        // Constant high level: INIT->HIGH without a count
        idle_cycle();
        run(G, M_C200, 1'b0, p, fc, lc, v, o, u);
        chk("c200_value", 32'(v), 32'd0);
        chk("c200_under", 32'(u), 32'd1);
        chk("c200_over",  32'(o), 32'd0);

        // Alternating 0/255 on the short gate
        idle_cycle();
        run(G, M_ALT, 1'b0, p, fc, lc, v, o, u);
        chk("alt_value", 32'(v), 32'd1600);
        chk("alt_over",  32'(o), 32'd0);
        chk("alt_under", 32'(u), 32'd0);

        // In-band toggling after LOW entry
        idle_cycle();
        run(G, M_BAND, 1'b0, p, fc, lc, v, o, u);
        chk("band_value", 32'(v), 32'd0);
        chk("band_under", 32'(u), 32'd1);
        en = 1'b0;

        // Long gate: just over the 8000 limit
        en2 = 1'b1;
        run(G2, M_ALT, 1'b1, p, fc, lc, v, o, u);
        chk("long_first_at", 32'(fc), 32'(G2));
        chk("long_value",    32'(v),  32'd8001);
        chk("long_over",     32'(o),  32'd1);
        chk("long_under",    32'(u),  32'd0);
        en2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/signal_frequency_meter.md
SIGNAL_FREQUENCY_METER -- requirements
Module: signal_frequency_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 32000, measurement window length in clock cycles; 1 s at 32 kHz, so the edge count equals Hz.
REQ-002 Parameter HYST_HIGH, default 8'd160, sample level at or above which the input is treated as high.
REQ-003 Parameter HYST_LOW, default 8'd96, sample level at or below which the input is treated as low; HYST_LOW < HYST_HIGH.
REQ-004 CLK_32KHz  in  1  sole clock; one unsigned 8-bit audio sample is presented per rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  high = measure; low = idle.
REQ-007 inputSample  in  8  unsigned sample, midscale 128, sampled on every rising edge.
REQ-008 outputFrequency  out  14  last completed window's rising-crossing count, in Hz.
REQ-009 frequencyValid  out  1  one-cycle pulse when outputFrequency updates.
REQ-010 overRange  out  1  last result > 8000.
REQ-011 underRange  out  1  last result < 100.

Function
REQ-012 Comparator FSM has exactly three states: INIT, LOW, HIGH.
REQ-013 INIT: sample >= HYST_HIGH -> HIGH; sample <= HYST_LOW -> LOW; no edge is counted; otherwise stay.
REQ-014 LOW -> HIGH when sample >= HYST_HIGH; that transition is one rising crossing.
REQ-015 HIGH -> LOW when sample <= HYST_LOW; samples strictly inside the band never change state.
REQ-016 Gate counter runs 0 .. GATE_CYCLES-1 while enable is high, then wraps to 0.
REQ-017 Edge counter is 14 bits, increments once per rising crossing, and saturates at 16383.
REQ-018 On the edge where the gate counter equals GATE_CYCLES-1:
- outputFrequency loads the edge count, including any crossing detected in that same cycle;
- overRange and underRange update from that value;
- frequencyValid is high for the following cycle only;
- the edge counter clears to 0.
REQ-019 A crossing in the final window cycle belongs to the closing window only, never to the next one.
REQ-020 Latency: first frequencyValid pulse arrives exactly GATE_CYCLES cycles after the first enabled cycle.
REQ-021 enable low:
- gate counter and edge counter clear to 0;
- FSM forced to INIT;
- frequencyValid held 0;
- outputFrequency, overRange and underRange hold their last values.
REQ-022 enable re-asserted starts a fresh window from gate count 0 in INIT.
REQ-023 frequencyValid is never asserted outside REQ-018.

Reset
REQ-024 While reset is high at a clock edge: outputFrequency=0, frequencyValid=0, overRange=0, underRange=0, FSM=INIT, both counters=0.
REQ-025 Reset has priority over enable and over window completion on the same edge.
REQ-026 Reset mid-window discards the partial count; the next pulse comes GATE_CYCLES enabled cycles after reset deasserts.

Structure
REQ-027 Shared package freq_meter_pkg holds:
- the comparator state enum (INIT/LOW/HIGH);
- the 8000/100 range limits;
- the 14-bit count width constant.
REQ-028 One sub-module, hysteresis_edge_detector, contains the FSM and emits a one-cycle risingCrossing strobe; the gate counter, edge counter and result registers live in the top.

Verification
REQ-029 Phase-accumulated 128-point triangle at 1000 Hz, enable high after reset -> frequencyValid at enabled cycles 32000 and 64000; outputFrequency 1000±1; both range flags 0.
REQ-030 Constant sample 8'd200 -> FSM INIT->HIGH with no count; outputFrequency=0; underRange=1.
REQ-031 Alternating 0/255 every cycle (16000 Hz) -> outputFrequency=16000, overRange=1.
REQ-032 Alternating 120/140 (inside hysteresis band) after a LOW entry -> zero crossings counted, outputFrequency=0.
REQ-033 Reset at enabled cycle 10000 of a 1000 Hz run -> all outputs 0 next cycle; next pulse 32000 cycles after reset deasserts, value 1000±1.
REQ-034 enable dropped at cycle 20000 for 50 cycles -> no pulse; prior outputFrequency held; next pulse 32000 cycles after re-enable.
